// File: rtl/video_timing_gen.sv
// Raster timing generator: walks the H/V counters, requests pixels from an upstream
// source and realigns the returned data with registered de/hs/vs/sof for an HDMI transmitter.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic        en,
    output logic        pixel_req,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb,
    output logic        de,
    output logic        hs,
    output logic        vs,
    output logic        sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEGIN  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON  = (HS_POL != 0);
    localparam logic HS_OFF = (HS_POL == 0);
    localparam logic VS_ON  = (VS_POL != 0);
    localparam logic VS_OFF = (VS_POL == 0);

    // Raw timing flags travel together through the delay line in this bit order.
    localparam int B_DE  = 0;
    localparam int B_HS  = 1;
    localparam int B_VS  = 2;
    localparam int B_SOF = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_run;

    logic [11:0] r_h_cnt;
    logic [10:0] r_v_cnt;

    logic        w_active;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_sof;
    logic [3:0]  w_raw;

    logic        r_pixel_req;
    logic [11:0] r_pix_x;
    logic [10:0] r_pix_y;
    logic [3:0]  r_raw_p;
    logic [3:0]  r_dly [PIPE_LAT];
    logic [3:0]  w_dly_out;

    logic        r_de;
    logic        r_hs;
    logic        r_vs;
    logic        r_sof;
    logic [23:0] r_rgb;

    // State register.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; counting only happens while running and still enabled, so a drop of en
    // clears everything on the very next edge.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_run       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Horizontal / vertical position counters.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 11'd0;
        end else if (!w_run) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 11'd0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= 12'd0;
            if (r_v_cnt == V_LAST) begin
                r_v_cnt <= 11'd0;
            end else begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Raw region decode from the current counter state.
    always_comb begin
        w_active = 1'b0;
        w_hsync  = 1'b0;
        w_vsync  = 1'b0;
        w_sof    = 1'b0;
        if (w_run) begin
            w_active = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
            w_hsync  = (r_h_cnt >= HS_BEGIN) && (r_h_cnt < HS_END);
            w_vsync  = (r_v_cnt >= VS_BEGIN) && (r_v_cnt < VS_END);
            w_sof    = w_active && (r_h_cnt == 12'd0) && (r_v_cnt == 11'd0);
        end else begin
            w_active = 1'b0;
            w_hsync  = 1'b0;
            w_vsync  = 1'b0;
            w_sof    = 1'b0;
        end
    end

    assign w_raw = {w_sof, w_vsync, w_hsync, w_active};

    // Request stage: coordinates are only driven while the request is live.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_pixel_req <= 1'b0;
            r_pix_x     <= 12'd0;
            r_pix_y     <= 11'd0;
            r_raw_p     <= 4'd0;
        end else if (w_active) begin
            r_pixel_req <= 1'b1;
            r_pix_x     <= r_h_cnt;
            r_pix_y     <= r_v_cnt;
            r_raw_p     <= w_raw;
        end else begin
            r_pixel_req <= 1'b0;
            r_pix_x     <= 12'd0;
            r_pix_y     <= 11'd0;
            r_raw_p     <= w_raw;
        end
    end

    // Delay line matching the pixel source latency; flushed rather than drained on stop.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_dly[k] <= 4'd0;
            end
        end else if (!w_run) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_dly[k] <= 4'd0;
            end
        end else begin
            r_dly[0] <= r_raw_p;
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
        end
    end

    assign w_dly_out = r_dly[PIPE_LAT-1];

    // Output register: rgb_in is only trusted when the aligned de is set.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_de  <= 1'b0;
            r_sof <= 1'b0;
            r_hs  <= HS_OFF;
            r_vs  <= VS_OFF;
            r_rgb <= 24'h000000;
        end else begin
            r_de  <= w_dly_out[B_DE];
            r_sof <= w_dly_out[B_SOF];
            r_hs  <= w_dly_out[B_HS] ? HS_ON : HS_OFF;
            r_vs  <= w_dly_out[B_VS] ? VS_ON : VS_OFF;
            if (w_dly_out[B_DE]) begin
                r_rgb <= rgb_in;
            end else begin
                r_rgb <= 24'h000000;
            end
        end
    end

    assign pixel_req = r_pixel_req;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign de        = r_de;
    assign hs        = r_hs;
    assign vs        = r_vs;
    assign sof       = r_sof;
    assign rgb       = r_rgb;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a shrunken raster (16x8 total, 8x4 active).
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 3, HT = 16;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1, VT = 8;
    localparam int FRAME = HT * VT;
    localparam int PL = 3;
    localparam int HSP = 1;
    localparam int VSP = 0;

    logic        clk_pixel = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pixel_req;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic [23:0] rgb_in;
    logic [23:0] rgb;
    logic        de, hs, vs, sof;

    always #5 clk_pixel = ~clk_pixel;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .PIPE_LAT(PL)
    ) dut (
        .clk_pixel(clk_pixel), .rst(rst), .en(en),
        .pixel_req(pixel_req), .pix_x(pix_x), .pix_y(pix_y),
        .rgb_in(rgb_in), .rgb(rgb), .de(de), .hs(hs), .vs(vs), .sof(sof)
    );

    // Pixel source: returns {y,x} PL cycles after a request, garbage otherwise.
    logic [23:0] src [PL];
    always @(posedge clk_pixel) begin
        src[0] <= pixel_req ? {1'b0, pix_y, pix_x} : 24'($urandom);
        for (int k = 1; k < PL; k++) src[k] <= src[k-1];
    end
    assign rgb_in = src[PL-1];

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    exp_q.push_back({1'b0, 11'(y), 12'(x)});
    endtask

    // Monitor state (written only by the monitor) and main-process control.
    bit tracking = 1'b0;
    bit seen_req = 1'b0;
    bit allow_start = 1'b0;
    int start_cyc = 0, sof_cyc = 0, req_cyc = 0, sof_count = 0;
    int de_cnt = 0, de_per_frame = -1, period = -1;
    int m_off, m_fo, m_ln, m_hp, m_fo2, m_ln2, m_hp2;
    bit m_req;

    always @(negedge clk_pixel) begin
        if (!allow_start) begin
            tracking = 1'b0;
            seen_req = 1'b0;
        end
        if (sof) sof_count++;
        if (!tracking && sof && allow_start) begin
            tracking = 1'b1;
            start_cyc = cyc;
            sof_cyc = cyc;
            de_cnt = 0;
            period = -1;
            de_per_frame = -1;
        end
        if (tracking) begin
            if (sof && cyc != sof_cyc) begin
                period = cyc - sof_cyc;
                de_per_frame = de_cnt;
                de_cnt = 0;
                sof_cyc = cyc;
            end
            m_off = cyc - start_cyc;
            m_fo = m_off % FRAME;
            m_ln = m_fo / HT;
            m_hp = m_fo % HT;
            chk("de", de, int'(m_ln < VA && m_hp < HA));
            chk("sof", sof, int'(m_fo == 0));
            chk("hs", hs, (m_hp >= HA + HF && m_hp < HA + HF + HSW) ? HSP : 1 - HSP);
            chk("vs", vs, (m_ln >= VA + VF && m_ln < VA + VF + VSW) ? VSP : 1 - VSP);
            if (de) begin
                de_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rgb_underflow: got de=1 with nothing queued, required de=0 (cycle %0d)", cyc);
                end else begin
                    chk("rgb", rgb, exp_q.pop_front());
                end
            end else begin
                chk("rgb_blank", rgb, 0);
            end
            if (en) begin
                m_fo2 = (m_off + PL + 1) % FRAME;
                m_ln2 = m_fo2 / HT;
                m_hp2 = m_fo2 % HT;
                m_req = (m_ln2 < VA) && (m_hp2 < HA);
                chk("pixel_req", pixel_req, m_req);
                chk("pix_x", pix_x, m_req ? m_hp2 : 0);
                chk("pix_y", pix_y, m_req ? m_ln2 : 0);
            end
        end else begin
            chk("idle_de", de, 0);
            chk("idle_sof", sof, 0);
            chk("idle_rgb", rgb, 0);
            chk("idle_hs", hs, 1 - HSP);
            chk("idle_vs", vs, 1 - VSP);
            if (!allow_start) begin
                chk("idle_req", pixel_req, 0);
                chk("idle_pix_x", pix_x, 0);
                chk("idle_pix_y", pix_y, 0);
            end else if (pixel_req && !seen_req) begin
                seen_req = 1'b1;
                req_cyc = cyc;
                chk("first_pix_x", pix_x, 0);
                chk("first_pix_y", pix_y, 0);
            end
        end
    end

    task automatic start_run(input int n);
        int c0;
        @(posedge clk_pixel); #2;
        push_frames(n);
        rst = 1'b0;
        en = 1'b1;
        allow_start = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 30 && !tracking; i++) begin
            @(posedge clk_pixel); #2;
        end
        chk("start_timeout", tracking, 1);
        if (tracking) begin
            chk("sof_latency", start_cyc - c0, PL + 3);
            chk("req_latency", req_cyc - c0, 2);
        end
    endtask

    // Caller is at posedge+2; en drops now, the one in-flight output is still checked.
    task automatic stop_run();
        en = 1'b0;
        @(posedge clk_pixel); #2;
        chk("req_after_drop", pixel_req, 0);
        chk("pix_x_after_drop", pix_x, 0);
        @(negedge clk_pixel); #1;
        allow_start = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_sof(input int target, input int budget);
        for (int i = 0; i < budget && sof_count < target; i++) begin
            @(posedge clk_pixel); #2;
        end
        chk("sof_wait_timeout", int'(sof_count >= target), 1);
    endtask

    task automatic wait_pix(input int x, input int y, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk_pixel); #2;
            hit = pixel_req && (pix_x == 12'(x)) && (pix_y == 11'(y));
        end
        chk("pix_wait_timeout", hit, 1);
    endtask

    int s0;

    initial begin
        // Reset, then idle with en low.
        repeat (5) @(posedge clk_pixel);
        #2;
        chk("rst_hs", hs, 1 - HSP);
        chk("rst_vs", vs, 1 - VSP);
        chk("rst_de", de, 0);
        chk("rst_req", pixel_req, 0);
        rst = 1'b0;
        repeat (100) @(posedge clk_pixel);
        #2;
        chk("idle_sof_count", sof_count, 0);

        // Two full frames, then drop en mid-frame at pixel (5,2).
        start_run(3);
        wait_sof(3, 3 * FRAME);
        chk("frame_period", period, FRAME);
        chk("de_per_frame", de_per_frame, HA * VA);
        wait_pix(5, 2, FRAME);
        stop_run();
        s0 = sof_count;
        repeat (20) @(posedge clk_pixel);
        #2;
        chk("sof_after_drop", sof_count, s0);

        // Restart, then async reset mid-frame on line 2.
        start_run(1);
        wait_pix(6, 2, FRAME);
        allow_start = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("arst_req", pixel_req, 0);
        chk("arst_pix_x", pix_x, 0);
        chk("arst_pix_y", pix_y, 0);
        chk("arst_de", de, 0);
        chk("arst_sof", sof, 0);
        chk("arst_rgb", rgb, 0);
        chk("arst_hs", hs, 1 - HSP);
        chk("arst_vs", vs, 1 - VSP);
        repeat (3) @(posedge clk_pixel);

        // Clean restart after reset, one full frame, then stop.
        start_run(2);
        s0 = sof_count;
        wait_sof(s0 + 1, 2 * FRAME);
        chk("frame_period_after_rst", period, FRAME);
        chk("de_per_frame_after_rst", de_per_frame, HA * VA);
        wait_pix(2, 1, FRAME);
        stop_run();
        repeat (5) @(posedge clk_pixel);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
